// File: rtl/mem_responder.sv
// Memory-side responder: a DEPTH x DWIDTH word array serving one read or write per
// chip-enable request, with WAIT_STATES extra cycles before the access.
module mem_responder #(
    parameter int DWIDTH      = 16,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  i_clr_reg,
    input  logic                  i_ce,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0]     i_data,
    output logic [DWIDTH-1:0]     o_data,
    output logic                  o_ready,
    output logic                  o_busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, HOLD} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0]     wdata_q, wdata_d;
    logic [DWIDTH-1:0]     rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic                  ready_q, ready_d;
    logic                  fire;
    logic                  mem_wr;

    logic [DWIDTH-1:0] mem [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_ce) begin
                    addr_d  = i_addr;
                    wdata_d = i_data;
                    we_d    = i_we;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    fire    = 1'b1;
                    ready_d = 1'b1;
                    state_d = DONE;
                    if (!we_q) rdata_d = mem[addr_q];
                end
            end
            // A still-asserted ce parks in HOLD so one level request is one transaction.
            DONE:    state_d = i_ce ? HOLD : IDLE;
            HOLD:    if (!i_ce) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_wr = fire & we_q;

    always_ff @(posedge clk or posedge i_clr_reg) begin
        if (i_clr_reg) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // Array is not reset; reset drops state to IDLE, which also kills a pending write.
    always_ff @(posedge clk) begin
        if (mem_wr) mem[addr_q] <= wdata_q;
    end

    assign o_data  = rdata_q;
    assign o_ready = ready_q;
    assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder with WAIT_STATES = 1, 0 and 3 instances.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        ce [3];
    logic        we [3];
    logic [11:0] ad [3];
    logic [15:0] wd [3];
    logic [15:0] rd [3];
    logic        rdy [3];
    logic        bsy [3];

    int ws_of [3] = '{1, 0, 3};

    int total = 0;
    int bad   = 0;

    logic [15:0] mdl [int];
    logic [15:0] mod_od [3];
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    mem_responder #(.DWIDTH(16), .ADDR_WIDTH(12), .WAIT_STATES(1)) dut_ws1 (
        .clk(clk), .i_clr_reg(rst), .i_ce(ce[0]), .i_we(we[0]), .i_addr(ad[0]),
        .i_data(wd[0]), .o_data(rd[0]), .o_ready(rdy[0]), .o_busy(bsy[0]));

    mem_responder #(.DWIDTH(16), .ADDR_WIDTH(12), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .i_clr_reg(rst), .i_ce(ce[1]), .i_we(we[1]), .i_addr(ad[1]),
        .i_data(wd[1]), .o_data(rd[1]), .o_ready(rdy[1]), .o_busy(bsy[1]));

    mem_responder #(.DWIDTH(16), .ADDR_WIDTH(12), .WAIT_STATES(3)) dut_ws3 (
        .clk(clk), .i_clr_reg(rst), .i_ce(ce[2]), .i_we(we[2]), .i_addr(ad[2]),
        .i_data(wd[2]), .o_data(rd[2]), .o_ready(rdy[2]), .o_busy(bsy[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on instance k; ce is held for 'hold' edges, inputs scrambled after acceptance if scr.
    task automatic txn(input int k, input logic w, input logic [11:0] a, input logic [15:0] d,
                       input int hold, input bit scr);
        int ws     = ws_of[k];
        int pulses = 0;
        int lat    = -1;
        int last   = ((hold > ws + 2) ? hold : ws + 2) + 3;
        logic [15:0] e;
        @(negedge clk);
        ce[k] = 1'b1; we[k] = w; ad[k] = a; wd[k] = d;
        if (w) mdl[k * 4096 + int'(a)] = d;
        else   mod_od[k] = mdl[k * 4096 + int'(a)];
        exp_q.push_back(mod_od[k]);
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            if (c >= hold) ce[k] = 1'b0;
            if (scr) begin we[k] = ~w; ad[k] = ~a; wd[k] = ~d; end
            chk($sformatf("busy_k%0d_c%0d", k, c), 32'(bsy[k]), 32'((c <= ws + 2) || (c <= hold)));
            if (rdy[k]) begin
                pulses++;
                if (lat < 0) lat = c - 1;
                chk($sformatf("sb_depth_k%0d", k), 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("data_at_ready_k%0d_a%03h", k, a), 32'(rd[k]), 32'(e));
                end
            end
        end
        if (pulses == 0 && exp_q.size() > 0) e = exp_q.pop_front();
        chk($sformatf("pulses_k%0d_a%03h", k, a), 32'(pulses), 32'd1);
        chk($sformatf("latency_k%0d_a%03h", k, a), 32'(lat), 32'(ws + 1));
        chk($sformatf("data_held_k%0d_a%03h", k, a), 32'(rd[k]), 32'(mod_od[k]));
        we[k] = 1'b0; ad[k] = '0; wd[k] = '0;
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ce[k] = 1'b0; we[k] = 1'b0; ad[k] = '0; wd[k] = '0; mod_od[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_data_k%0d", k), 32'(rd[k]), 32'd0);
            chk($sformatf("rst_ready_k%0d", k), 32'(rdy[k]), 32'd0);
            chk($sformatf("rst_busy_k%0d", k), 32'(bsy[k]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Write then read back, o_data untouched by the write.
        txn(0, 1'b1, 12'h010, 16'hBEEF, 1, 1'b0);
        txn(0, 1'b0, 12'h010, 16'h0000, 1, 1'b0);

        // ce held high for 10 edges: one transaction only.
        txn(0, 1'b0, 12'h010, 16'h0000, 10, 1'b0);

        // Both ends of the address range.
        txn(0, 1'b1, 12'hFFF, 16'h1234, 1, 1'b0);
        txn(0, 1'b1, 12'h000, 16'h5678, 1, 1'b0);
        txn(0, 1'b0, 12'hFFF, 16'h0000, 1, 1'b0);
        txn(0, 1'b0, 12'h000, 16'h0000, 1, 1'b0);

        // Reset during ACCESS of a write over an existing value.
        txn(0, 1'b1, 12'h020, 16'h0001, 1, 1'b0);
        @(negedge clk);
        ce[0] = 1'b1; we[0] = 1'b1; ad[0] = 12'h020; wd[0] = 16'hAAAA;
        @(posedge clk); #1;
        ce[0] = 1'b0;
        chk("midwr_busy_before_rst", 32'(bsy[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midwr_busy_after_rst", 32'(bsy[0]), 32'd0);
        chk("midwr_data_after_rst", 32'(rd[0]), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk($sformatf("midwr_no_ready_%0d", c), 32'(rdy[0]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) mod_od[k] = '0;
        @(posedge clk); #1;
        chk("midwr_no_ready_post", 32'(rdy[0]), 32'd0);
        chk("midwr_data_post", 32'(rd[0]), 32'd0);
        txn(0, 1'b0, 12'h020, 16'h0000, 1, 1'b0);

        // Read latency for each wait-state build, with inputs scrambled mid-ACCESS.
        txn(0, 1'b0, 12'hFFF, 16'h0000, 1, 1'b1);
        txn(1, 1'b1, 12'h055, 16'hC0DE, 1, 1'b0);
        txn(1, 1'b1, 12'h056, 16'h7E57, 1, 1'b1);
        txn(1, 1'b0, 12'h055, 16'h0000, 1, 1'b1);
        txn(1, 1'b0, 12'h056, 16'h0000, 1, 1'b0);
        txn(2, 1'b1, 12'h055, 16'hC0DE, 1, 1'b0);
        txn(2, 1'b1, 12'h3A0, 16'h0F0F, 1, 1'b1);
        txn(2, 1'b0, 12'h055, 16'h0000, 1, 1'b1);
        txn(2, 1'b0, 12'h3A0, 16'h0000, 4, 1'b0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
